execute_stage: RTL and testbench

- Processor Execute stage: takes the ID/EX operands and controls, and computes the ALU result, destination register and store data.
- Drives the EX/MEM register that feeds the Memory stage (RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM).
- Adds an iterative shift-add multiplier whose FSM stalls upstream while busy and inserts bubbles downstream.

---
 rtl/exec_pkg.sv | 38 +++
 rtl/iter_multiplier.sv | 88 ++++++++
 rtl/execute_stage.sv | 147 ++++++++++++++
 tb/tb_execute_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, multiplier FSM states and the EX/MEM bubble.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_XOR = 4'd3,
        ALU_NOR = 4'd4,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_SRA = 4'd10,
        ALU_MUL = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [4:0] write_reg;
    } exmem_ctrl_t;

    localparam exmem_ctrl_t BUBBLE_CTRL = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        write_reg:  5'd0
    };

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier (low DATA_W bits of the unsigned product), RADIX_BITS per step.
// busy is combinational in IDLE so a start request stalls upstream in the same cycle.
module iter_multiplier
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int STEPS = DATA_W / RADIX_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    mul_state_e        state, state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mcand, mplier, acc, partial;
    logic              last_step;

    assign last_step = (count == CNT_W'(STEPS - 1));
    assign product   = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort wins over every transition so a flushed multiply never reaches DONE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: begin
                busy = start;
                if (start) state_next = MUL_BUSY;
            end
            MUL_BUSY: begin
                busy = 1'b1;
                if (last_step) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
        if (abort) state_next = MUL_IDLE;
    end

    always_comb begin
        partial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == MUL_IDLE && start) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (state == MUL_BUSY) begin
            count  <= count + CNT_W'(1);
            acc    <= acc + partial;
            mcand  <= mcand << RADIX_BITS;
            mplier <= mplier >> RADIX_BITS;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, iterative multiplier and the EX/MEM pipeline register.
// Optional macro EXEC_OVF_EN adds OverflowM and suppresses RegWriteM on signed ADD/SUB overflow.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic [3:0]        ALUControlE,
    input  logic              ALUSrcE,
    input  logic              RegDstE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [4:0]        RtE,
    input  logic [4:0]        RdE,
    input  logic [4:0]        ShamtE,
    input  logic              FlushE,
    output logic              Busy,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic [4:0]        WriteRegM,
    output logic [DATA_W-1:0] ALUResultM,
`ifdef EXEC_OVF_EN
    output logic              OverflowM,
`endif
    output logic [DATA_W-1:0] WriteDataM
);

    alu_op_e           op;
    logic [DATA_W-1:0] src_b, sum, diff, alu_result, product;
    logic [DATA_W-1:0] result_m, data_m;
    logic [4:0]        write_reg;
    logic              mul_op, mul_busy, mul_done, reg_write, load_bubble;
    exmem_ctrl_t       ctrl, ctrl_m;

    assign op          = alu_op_e'(ALUControlE);
    assign src_b       = ALUSrcE ? SignImmE : RD2E;
    assign write_reg   = RegDstE ? RdE : RtE;
    assign sum         = RD1E + src_b;
    assign diff        = RD1E - src_b;
    assign mul_op      = (op == ALU_MUL);
    assign load_bubble = !ValidE || mul_op || mul_busy;

    iter_multiplier #(
        .DATA_W     (DATA_W),
        .RADIX_BITS (RADIX_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (ValidE && mul_op),
        .abort   (FlushE),
        .a       (RD1E),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    assign Busy = mul_busy;

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_AND: alu_result = RD1E & src_b;
            ALU_OR:  alu_result = RD1E | src_b;
            ALU_ADD: alu_result = sum;
            ALU_XOR: alu_result = RD1E ^ src_b;
            ALU_NOR: alu_result = ~(RD1E | src_b);
            ALU_SUB: alu_result = diff;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(RD1E) < $signed(src_b))};
            ALU_SLL: alu_result = src_b << ShamtE;
            ALU_SRL: alu_result = src_b >> ShamtE;
            ALU_SRA: alu_result = $signed(src_b) >>> ShamtE;
            default: alu_result = '0;
        endcase
    end

`ifdef EXEC_OVF_EN
    logic overflow;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        overflow = 1'b0;
        if (op == ALU_ADD) begin
            overflow = (RD1E[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != RD1E[DATA_W-1]);
        end else if (op == ALU_SUB) begin
            overflow = (RD1E[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != RD1E[DATA_W-1]);
        end
    end

    assign reg_write = RegWriteE && !overflow;

    always_ff @(posedge clk) begin
        if (rst || FlushE || mul_done || load_bubble) begin
            OverflowM <= 1'b0;
        end else begin
            OverflowM <= overflow;
        end
    end
`else
    assign reg_write = RegWriteE;
`endif

    assign ctrl = '{
        reg_write:  reg_write,
        mem_to_reg: MemtoRegE,
        mem_write:  MemWriteE,
        write_reg:  write_reg
    };

    // Priority: reset, flush, finished product, bubble, then the ordinary single-cycle result.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            ctrl_m   <= BUBBLE_CTRL;
            result_m <= '0;
            data_m   <= '0;
        end else if (mul_done) begin
            ctrl_m   <= ctrl;
            result_m <= product;
            data_m   <= RD2E;
        end else if (load_bubble) begin
            ctrl_m   <= BUBBLE_CTRL;
            result_m <= '0;
            data_m   <= '0;
        end else begin
            ctrl_m   <= ctrl;
            result_m <= alu_result;
            data_m   <= RD2E;
        end
    end

    assign RegWriteM  = ctrl_m.reg_write;
    assign MemtoRegM  = ctrl_m.mem_to_reg;
    assign MemWriteM  = ctrl_m.mem_write;
    assign WriteRegM  = ctrl_m.write_reg;
    assign ALUResultM = result_m;
    assign WriteDataM = data_m;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: ALU ops, multiplier timing, flush, reset and optional overflow.
module tb_execute_stage;
    import exec_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, FlushE;
    logic [3:0]   ALUControlE;
    logic [W-1:0] RD1E, RD2E, SignImmE;
    logic [4:0]   RtE, RdE, ShamtE;
    logic         Busy, RegWriteM, MemtoRegM, MemWriteM;
    logic [4:0]   WriteRegM;
    logic [W-1:0] ALUResultM, WriteDataM;
`ifdef EXEC_OVF_EN
    logic         OverflowM;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src, dst;
        logic [4:0]  rt, rd, sh;
        logic [31:0] exp;
        logic [4:0]  wr;
    } alu_vec_t;

    alu_vec_t vecs[14];

    execute_stage #(.DATA_W(W), .RADIX_BITS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ValidE      (ValidE),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .MemWriteE   (MemWriteE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RegDstE     (RegDstE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .SignImmE    (SignImmE),
        .RtE         (RtE),
        .RdE         (RdE),
        .ShamtE      (ShamtE),
        .FlushE      (FlushE),
        .Busy        (Busy),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .WriteRegM   (WriteRegM),
        .ALUResultM  (ALUResultM),
`ifdef EXEC_OVF_EN
        .OverflowM   (OverflowM),
`endif
        .WriteDataM  (WriteDataM)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic valid, input logic [3:0] op, input logic [31:0] a, b, imm,
                          input logic src, dst, input logic [4:0] rt, rd, sh);
        ValidE      = valid;
        ALUControlE = op;
        RD1E        = a;
        RD2E        = b;
        SignImmE    = imm;
        ALUSrcE     = src;
        RegDstE     = dst;
        RtE         = rt;
        RdE         = rd;
        ShamtE      = sh;
        RegWriteE   = 1'b1;
        MemtoRegE   = 1'b0;
        MemWriteE   = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        FlushE = 1'b0;
        set_op(1'b1, ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0);
        tick;
        tick;
        compared++;
        if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_m_outputs: got res=%h wr=%0d rw=%b, expected all zero", ALUResultM, WriteRegM, RegWriteM);
        end
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", Busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu;
        vecs[0]  = '{ALU_ADD, 32'd7,        32'd5,        32'd0,        1'b0, 1'b1, 5'd0, 5'd9,  5'd0,  32'd12,       5'd9};
        vecs[1]  = '{ALU_SUB, 32'd3,        32'd5,        32'd0,        1'b0, 1'b1, 5'd0, 5'd10, 5'd0,  32'hFFFFFFFE, 5'd10};
        vecs[2]  = '{ALU_SLT, 32'hFFFFFFFD, 32'd2,        32'd0,        1'b0, 1'b1, 5'd0, 5'd11, 5'd0,  32'd1,        5'd11};
        vecs[3]  = '{ALU_SLT, 32'd2,        32'hFFFFFFFD, 32'd0,        1'b0, 1'b1, 5'd0, 5'd12, 5'd0,  32'd0,        5'd12};
        vecs[4]  = '{ALU_SRA, 32'd0,        32'h80000000, 32'd0,        1'b0, 1'b1, 5'd0, 5'd13, 5'd4,  32'hF8000000, 5'd13};
        vecs[5]  = '{ALU_SRL, 32'd0,        32'h80000000, 32'd0,        1'b0, 1'b1, 5'd0, 5'd14, 5'd4,  32'h08000000, 5'd14};
        vecs[6]  = '{ALU_SLL, 32'd0,        32'd1,        32'd0,        1'b0, 1'b1, 5'd0, 5'd15, 5'd31, 32'h80000000, 5'd15};
        vecs[7]  = '{ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        1'b0, 1'b1, 5'd0, 5'd16, 5'd0,  32'h00F000F0, 5'd16};
        vecs[8]  = '{ALU_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        1'b0, 1'b1, 5'd0, 5'd17, 5'd0,  32'hFFF0FFF0, 5'd17};
        vecs[9]  = '{ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        1'b0, 1'b1, 5'd0, 5'd18, 5'd0,  32'hFF00FF00, 5'd18};
        vecs[10] = '{ALU_NOR, 32'd0,        32'd0,        32'd0,        1'b0, 1'b1, 5'd0, 5'd19, 5'd0,  32'hFFFFFFFF, 5'd19};
        vecs[11] = '{ALU_ADD, 32'd10,       32'h55,       32'hFFFFFFFF, 1'b1, 1'b0, 5'd4, 5'd20, 5'd0,  32'd9,        5'd4};
        vecs[12] = '{4'd5,    32'd1,        32'd2,        32'd0,        1'b0, 1'b1, 5'd0, 5'd21, 5'd0,  32'd0,        5'd21};
        vecs[13] = '{ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 5'd0, 5'd22, 5'd0,  32'd0,        5'd22};
        for (int i = 0; i < 14; i++) begin
            set_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, vecs[i].dst,
                   vecs[i].rt, vecs[i].rd, vecs[i].sh);
            tick;
            compared++;
            if (ALUResultM !== vecs[i].exp) begin
                mismatched++;
                $display("[TB] FAIL alu_result[%0d]: got %h expected %h", i, ALUResultM, vecs[i].exp);
            end
            compared++;
            if (WriteRegM !== vecs[i].wr) begin
                mismatched++;
                $display("[TB] FAIL alu_write_reg[%0d]: got %0d expected %0d", i, WriteRegM, vecs[i].wr);
            end
            compared++;
            if (RegWriteM !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL alu_reg_write[%0d]: got %b expected 1", i, RegWriteM);
            end
            compared++;
            if (WriteDataM !== vecs[i].b) begin
                mismatched++;
                $display("[TB] FAIL alu_write_data[%0d]: got %h expected %h", i, WriteDataM, vecs[i].b);
            end
        end
        // store-like instruction: memory controls travel through unchanged
        set_op(1'b1, ALU_ADD, 32'd100, 32'hDEADBEEF, 32'd8, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        RegWriteE = 1'b0;
        MemWriteE = 1'b1;
        MemtoRegE = 1'b1;
        tick;
        compared++;
        if ({RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM} !== {3'b011, 32'd108, 32'hDEADBEEF}) begin
            mismatched++;
            $display("[TB] FAIL store_ctrl: got rw=%b m2r=%b mw=%b res=%h data=%h expected 0 1 1 0000006c deadbeef",
                     RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM);
        end
    endtask

    task automatic test_mul;
        logic [31:0] ma[2];
        logic [31:0] mb[2];
        logic [31:0] mp[2];
        int busy_cycles, bubbles;
        ma[0] = 32'd6;        mb[0] = 32'd7; mp[0] = 32'd42;
        ma[1] = 32'hFFFFFFFF; mb[1] = 32'd2; mp[1] = 32'hFFFFFFFE;
        for (int k = 0; k < 2; k++) begin
            set_op(1'b1, ALU_MUL, ma[k], mb[k], 32'd0, 1'b0, 1'b1, 5'd0, 5'(3 + k), 5'd0);
            busy_cycles = 0;
            bubbles     = 0;
            while (Busy === 1'b1 && busy_cycles < 100) begin
                busy_cycles++;
                tick;
                if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} === '0) bubbles++;
            end
            compared++;
            if (busy_cycles != 33) begin
                mismatched++;
                $display("[TB] FAIL mul_busy_cycles[%0d]: got %0d expected 33", k, busy_cycles);
            end
            compared++;
            if (bubbles != 33) begin
                mismatched++;
                $display("[TB] FAIL mul_bubbles[%0d]: got %0d expected 33", k, bubbles);
            end
            tick;
            compared++;
            if (ALUResultM !== mp[k]) begin
                mismatched++;
                $display("[TB] FAIL mul_product[%0d]: got %h expected %h", k, ALUResultM, mp[k]);
            end
            compared++;
            if ({RegWriteM, WriteRegM} !== {1'b1, 5'(3 + k)}) begin
                mismatched++;
                $display("[TB] FAIL mul_ctrl[%0d]: got rw=%b wr=%0d expected rw=1 wr=%0d", k, RegWriteM, WriteRegM, 3 + k);
            end
        end
        set_op(1'b0, ALU_AND, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_flush;
        int guard;
        set_op(1'b1, ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0);
        tick;
        repeat (10) tick;
        FlushE = 1'b1;
        #1;
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL flush_busy_before: got %b expected 1", Busy);
        end
        tick;
        FlushE = 1'b0;
        compared++;
        if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} !== '0) begin
            mismatched++;
            $display("[TB] FAIL flush_busy_bubble: got res=%h rw=%b expected zero", ALUResultM, RegWriteM);
        end
        set_op(1'b1, ALU_ADD, 32'd100, 32'd23, 32'd0, 1'b0, 1'b1, 5'd0, 5'd5, 5'd0);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_busy_after: got %b expected 0", Busy);
        end
        tick;
        compared++;
        if ({RegWriteM, WriteRegM, ALUResultM} !== {1'b1, 5'd5, 32'd123}) begin
            mismatched++;
            $display("[TB] FAIL flush_next_add: got rw=%b wr=%0d res=%h expected 1 5 0000007b", RegWriteM, WriteRegM, ALUResultM);
        end
        // flush beats an ordinary single-cycle load
        set_op(1'b1, ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 5'd0);
        FlushE = 1'b1;
        tick;
        FlushE = 1'b0;
        compared++;
        if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} !== '0) begin
            mismatched++;
            $display("[TB] FAIL flush_normal_bubble: got res=%h rw=%b expected zero", ALUResultM, RegWriteM);
        end
        // flush beats the DONE product load
        set_op(1'b1, ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0);
        guard = 0;
        while (Busy === 1'b1 && guard < 100) begin
            guard++;
            tick;
        end
        FlushE = 1'b1;
        tick;
        FlushE = 1'b0;
        set_op(1'b0, ALU_AND, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        compared++;
        if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} !== '0) begin
            mismatched++;
            $display("[TB] FAIL flush_done_bubble: got res=%h rw=%b expected zero (guard=%0d)", ALUResultM, RegWriteM, guard);
        end
    endtask

    task automatic test_valid_low;
        set_op(1'b1, ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0);
        tick;
        set_op(1'b0, ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0);
        tick;
        compared++;
        if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} !== '0) begin
            mismatched++;
            $display("[TB] FAIL valid_low_bubble: got res=%h wr=%0d rw=%b expected zero", ALUResultM, WriteRegM, RegWriteM);
        end
        set_op(1'b0, ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL valid_low_mul_busy: got %b expected 0", Busy);
        end
    endtask

    task automatic test_reset_mid_mul;
        logic clean;
        set_op(1'b1, ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0);
        tick;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_op(1'b0, ALU_AND, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_mul_busy: got %b expected 0", Busy);
        end
        clean = 1'b1;
        repeat (40) begin
            tick;
            if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUResultM, WriteDataM} !== '0) clean = 1'b0;
        end
        compared++;
        if (clean !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_mul_no_partial: got nonzero M output (res=%h) expected zero throughout", ALUResultM);
        end
        set_op(1'b1, ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 5'd0, 5'd8, 5'd0);
        tick;
        compared++;
        if ({RegWriteM, WriteRegM, ALUResultM} !== {1'b1, 5'd8, 32'd5}) begin
            mismatched++;
            $display("[TB] FAIL rst_mul_next_add: got rw=%b wr=%0d res=%h expected 1 8 00000005", RegWriteM, WriteRegM, ALUResultM);
        end
    endtask

    task automatic test_overflow;
        logic exp_rw;
`ifdef EXEC_OVF_EN
        exp_rw = 1'b0;
`else
        exp_rw = 1'b1;
`endif
        set_op(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd7, 5'd0);
        tick;
        compared++;
        if ({RegWriteM, ALUResultM} !== {exp_rw, 32'h80000000}) begin
            mismatched++;
            $display("[TB] FAIL ovf_add: got rw=%b res=%h expected rw=%b res=80000000", RegWriteM, ALUResultM, exp_rw);
        end
`ifdef EXEC_OVF_EN
        compared++;
        if (OverflowM !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_add_flag: got %b expected 1", OverflowM);
        end
`endif
        set_op(1'b1, ALU_SUB, 32'h80000000, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd7, 5'd0);
        tick;
        compared++;
        if ({RegWriteM, ALUResultM} !== {exp_rw, 32'h7FFFFFFF}) begin
            mismatched++;
            $display("[TB] FAIL ovf_sub: got rw=%b res=%h expected rw=%b res=7fffffff", RegWriteM, ALUResultM, exp_rw);
        end
        set_op(1'b1, ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd7, 5'd0);
        tick;
        compared++;
        if ({RegWriteM, ALUResultM} !== {1'b1, 32'd2}) begin
            mismatched++;
            $display("[TB] FAIL ovf_none: got rw=%b res=%h expected rw=1 res=00000002", RegWriteM, ALUResultM);
        end
`ifdef EXEC_OVF_EN
        compared++;
        if (OverflowM !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_none_flag: got %b expected 0", OverflowM);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_alu;
        test_mul;
        test_flush;
        test_valid_low;
        test_reset_mid_mul;
        test_overflow;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
